trig_series_unit: RTL and testbench

Parametrised sequential Taylor-series evaluator. Computes cos(x) or sin(x) for an unsigned fractional angle x in [0,1), using a run-time selectable number of series terms. It is the generalised successor of the fixed-width cosine engine:
- adds a sine mode, parametrised width and term limit;
- adds a busy flag and a held result with acknowledge (backpressure).
One shared multiplier, with controller and datapath inside one module.

---
 rtl/trig_series_unit.sv | 167 ++++++++++++++++
 tb/tb_trig_series_unit.sv | 138 +++++++++++++
 2 files changed

// File: rtl/trig_series_unit.sv
// Sequential Taylor-series cos/sin evaluator sharing one multiplier.
// Latency 2*N edges from start to ans_ready; ans is held until ans_ack.
module trig_series_unit #(
  parameter int W         = 16,
  parameter int MAX_TERMS = 8,
  parameter int NT_W      = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            mode,
  input  logic [W-1:0]    the_x,
  input  logic [NT_W-1:0] n_terms,
  input  logic            ans_ack,
  output logic            busy,
  output logic [W-1:0]    ans,
  output logic            ans_ready
);

  localparam int KW = 8;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] SQR  = 3'd1;
  localparam logic [2:0] MULX = 3'd2;
  localparam logic [2:0] MULC = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  function automatic logic [W-1:0] coef(input bit sine, input int k);
    longint num;
    longint den;
    num = longint'(1) << W;
    den = sine ? longint'(2 * k) * longint'(2 * k + 1)
               : longint'(2 * k - 1) * longint'(2 * k);
    return W'(num / den);
  endfunction

  logic [W-1:0] cos_tab [MAX_TERMS];
  logic [W-1:0] sin_tab [MAX_TERMS];

  // Entry 0 is never used; k starts at 1.
  for (genvar gi = 0; gi < MAX_TERMS; gi++) begin : g_tab
    if (gi == 0) begin : g_zero
      assign cos_tab[gi] = '0;
      assign sin_tab[gi] = '0;
    end else begin : g_coef
      assign cos_tab[gi] = coef(1'b0, gi);
      assign sin_tab[gi] = coef(1'b1, gi);
    end
  end

  logic [2:0]          state;
  logic [W-1:0]        x_r;
  logic                mode_r;
  logic [KW-1:0]       n_r;
  logic [KW-1:0]       k;
  logic [W-1:0]        x2;
  logic [W:0]          term;
  logic signed [W+1:0] acc;

  logic [W-1:0]        r_val;
  logic [W:0]          mul_a;
  logic [W-1:0]        mul_b;
  logic [2*W:0]        prod;
  logic [W:0]          prod_sh;
  logic signed [W+1:0] term_ext;
  logic [W:0]          term_init;
  logic [W-1:0]        ans_sat;
  logic [KW-1:0]       k_next;

  always_comb begin
    r_val = '0;
    for (int i = 1; i < MAX_TERMS; i++) begin
      if (k == KW'(i)) r_val = mode_r ? sin_tab[i] : cos_tab[i];
    end
  end

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state)
      SQR: begin
        mul_a = {1'b0, x_r};
        mul_b = x_r;
      end
      MULX: begin
        mul_a = term;
        mul_b = x2;
      end
      MULC: begin
        mul_a = term;
        mul_b = r_val;
      end
      default: ;
    endcase
  end

  assign prod      = (2*W+1)'(mul_a) * (2*W+1)'(mul_b);
  assign prod_sh   = prod[2*W:W];
  assign term_ext  = {1'b0, prod_sh};
  assign term_init = mode_r ? {1'b0, x_r} : {1'b1, {W{1'b0}}};
  assign k_next    = k + KW'(1);

  // acc is W+2 bits signed, so a non-negative acc>>1 always fits in W bits.
  assign ans_sat = acc[W+1] ? '0 : acc[W:1];

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      x_r       <= '0;
      mode_r    <= 1'b0;
      n_r       <= '0;
      k         <= '0;
      x2        <= '0;
      term      <= '0;
      acc       <= '0;
      ans       <= '0;
      ans_ready <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            x_r    <= the_x;
            mode_r <= mode;
            if (n_terms == '0)
              n_r <= KW'(1);
            else if (32'(n_terms) > 32'(MAX_TERMS))
              n_r <= KW'(MAX_TERMS);
            else
              n_r <= KW'(n_terms);
            state <= SQR;
          end
        end
        SQR: begin
          x2    <= prod_sh[W-1:0];
          term  <= term_init;
          acc   <= {1'b0, term_init};
          k     <= KW'(1);
          state <= (n_r == KW'(1)) ? DONE : MULX;
        end
        MULX: begin
          term  <= prod_sh;
          state <= MULC;
        end
        MULC: begin
          term  <= prod_sh;
          acc   <= k[0] ? (acc - term_ext) : (acc + term_ext);
          k     <= k_next;
          state <= (k_next == n_r) ? DONE : MULX;
        end
        DONE: begin
          // First DONE cycle publishes the result; the ack is honoured only after that.
          if (!ans_ready) begin
            ans       <= ans_sat;
            ans_ready <= 1'b1;
          end else if (ans_ack) begin
            ans_ready <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trig_series_unit.sv
// Directed bench for trig_series_unit: results, latency, handshake and async reset.
module tb_trig_series_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [15:0] the_x = '0;
  logic [7:0]  n_terms = '0;
  logic        ans_ack = 1'b0;
  logic        busy;
  logic [15:0] ans;
  logic        ans_ready;

  int checks = 0;
  int errors = 0;

  trig_series_unit #(.W(16), .MAX_TERMS(8), .NT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .the_x     (the_x),
    .n_terms   (n_terms),
    .ans_ack   (ans_ack),
    .busy      (busy),
    .ans       (ans),
    .ans_ready (ans_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Issue one request, optionally poke start with a different angle while busy.
  task automatic run_req(input string tag, input logic md, input logic [15:0] x,
                         input logic [7:0] n, input int exp_ans, input int exp_lat,
                         input bit poke);
    int lat;
    @(posedge clk); #1;
    start = 1'b1; mode = md; the_x = x; n_terms = n;
    @(posedge clk); #1;
    start = 1'b0; mode = ~md; the_x = 16'h1234; n_terms = 8'd1;
    check({tag, " busy"}, busy, 1);
    lat = 0;
    while (!ans_ready && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (poke && lat == 2) begin
        start = 1'b1; the_x = 16'h0000; mode = md;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " ans"}, ans, exp_ans);
  endtask

  task automatic do_ack(input string tag, input bit with_start);
    ans_ack = 1'b1;
    start   = with_start;
    @(posedge clk); #1;
    ans_ack = 1'b0;
    start   = 1'b0;
    check({tag, " ready after ack"}, ans_ready, 0);
    check({tag, " busy after ack"}, busy, 0);
  endtask

  initial begin
    #1;
    check("reset busy", busy, 0);
    check("reset ready", ans_ready, 0);
    check("reset ans", ans, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_req("cos x0 n4", 1'b0, 16'd0, 8'd4, 32768, 8, 1'b0);
    do_ack("cos x0 n4", 1'b0);

    run_req("cos x.5 n3", 1'b0, 16'd32768, 8'd3, 28757, 6, 1'b0);
    repeat (10) begin
      @(posedge clk); #1;
    end
    check("hold ready", ans_ready, 1);
    check("hold ans", ans, 28757);
    check("hold busy", busy, 1);
    do_ack("cos x.5 n3", 1'b0);

    run_req("sin x.5 n2", 1'b1, 16'd32768, 8'd2, 15701, 4, 1'b0);
    do_ack("sin x.5 n2 ack+start", 1'b1);
    @(posedge clk); #1;
    check("start on ack ignored", busy, 0);

    run_req("sin x0 n5", 1'b1, 16'd0, 8'd5, 0, 10, 1'b0);
    do_ack("sin x0 n5", 1'b0);

    run_req("cos n0", 1'b0, 16'd32768, 8'd0, 32768, 2, 1'b0);
    do_ack("cos n0", 1'b0);

    run_req("cos x.5 n8", 1'b0, 16'd32768, 8'd8, 28756, 16, 1'b0);
    do_ack("cos x.5 n8", 1'b0);

    run_req("cos x.5 n200", 1'b0, 16'd32768, 8'd200, 28756, 16, 1'b0);
    do_ack("cos x.5 n200", 1'b0);

    run_req("cos busy poke", 1'b0, 16'd32768, 8'd3, 28757, 6, 1'b1);
    do_ack("cos busy poke", 1'b0);

    // Abort in MULC: two edges after the sampling edge the engine sits in MULC.
    @(posedge clk); #1;
    start = 1'b1; mode = 1'b0; the_x = 16'd32768; n_terms = 8'd8;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre-abort busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("abort busy", busy, 0);
    check("abort ready", ans_ready, 0);
    check("abort ans", ans, 0);
    #1 rst = 1'b0;

    run_req("sin after reset", 1'b1, 16'd32768, 8'd2, 15701, 4, 1'b0);
    do_ack("sin after reset", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
